// File: rtl/ata_pkg.sv
// ata_pkg: shared PIO arbiter/controller state encoding and default bus widths.
package ata_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;
    localparam int AW_DEF = 4;
    localparam int DW_DEF = 16;
endpackage

// File: rtl/ata_rr_pick.sv
// ata_rr_pick: combinational 2-way round-robin picker; on a tie the requester
// that was not served last wins.
module ata_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);
    assign valid  = req0 | req1;
    assign winner = (req0 & req1) ? ~last : req1;
endmodule

// File: rtl/ata_pio_arbiter.sv
// ata_pio_arbiter: round-robin share of the ATA PIO port between two requesters.
// Optional ATA_ARB_LOCK_EN lets the owner keep the grant for up to LOCK_MAX accesses.
module ata_pio_arbiter
    import ata_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int LOCK_MAX = 256
) (
    input  logic          CLK_I,
    input  logic          nReset,
    input  logic          req0,
    input  logic [AW-1:0] adr0,
    input  logic [DW-1:0] dat0,
    input  logic          we0,
    input  logic          lock0,
    output logic          ack0,
    input  logic          req1,
    input  logic [AW-1:0] adr1,
    input  logic [DW-1:0] dat1,
    input  logic          we1,
    input  logic          lock1,
    output logic          ack1,
    output logic [DW-1:0] q,
    output logic          PIOsel,
    output logic [AW-1:0] PIOa,
    output logic [DW-1:0] PIOd,
    output logic          PIOwe,
    input  logic          PIOack,
    input  logic [DW-1:0] PIOq,
    output logic          busy,
    output logic          owner
);
    state_t        state, state_n;
    logic          last, last_n, owner_n, sel_n, we_n;
    logic [AW-1:0] a_n;
    logic [DW-1:0] d_n;
    logic          pick_valid, pick_winner, ack_hit;

    ata_rr_pick u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // PIOsel is low for one cycle inside ACCESS during a locked re-grant; acks are only taken while selected
    assign ack_hit = (state == ST_ACCESS) && PIOsel && PIOack;
    assign ack0    = ack_hit & ~owner;
    assign ack1    = ack_hit & owner;
    assign q       = ack_hit ? PIOq : '0;
    assign busy    = (state == ST_ACCESS);

`ifdef ATA_ARB_LOCK_EN
    logic [8:0] lock_cnt, cnt_n;
    logic       keep;
    assign keep = (owner ? (lock1 & req1) : (lock0 & req0)) && (lock_cnt < 9'(LOCK_MAX - 1));
`else
    logic unused_lock;
    assign unused_lock = lock0 ^ lock1;
`endif

    always_comb begin
        state_n = state;
        last_n  = last;
        owner_n = owner;
        sel_n   = PIOsel;
        a_n     = PIOa;
        d_n     = PIOd;
        we_n    = PIOwe;
`ifdef ATA_ARB_LOCK_EN
        cnt_n   = lock_cnt;
`endif
        if (state == ST_IDLE) begin
            if (pick_valid) begin
                state_n = ST_ACCESS;
                owner_n = pick_winner;
                sel_n   = 1'b1;
                a_n     = pick_winner ? adr1 : adr0;
                d_n     = pick_winner ? dat1 : dat0;
                we_n    = pick_winner ? we1 : we0;
            end
        end else if (!PIOsel) begin
            sel_n = 1'b1;
        end else if (PIOack) begin
            sel_n = 1'b0;
`ifdef ATA_ARB_LOCK_EN
            if (keep) begin
                a_n   = owner ? adr1 : adr0;
                d_n   = owner ? dat1 : dat0;
                we_n  = owner ? we1 : we0;
                cnt_n = lock_cnt + 9'd1;
            end else begin
                state_n = ST_IDLE;
                last_n  = owner;
                cnt_n   = '0;
            end
`else
            state_n = ST_IDLE;
            last_n  = owner;
`endif
        end
    end

    always_ff @(posedge CLK_I or negedge nReset) begin
        if (!nReset) begin
            state  <= ST_IDLE;
            last   <= 1'b1;
            owner  <= 1'b0;
            PIOsel <= 1'b0;
            PIOa   <= '0;
            PIOd   <= '0;
            PIOwe  <= 1'b0;
        end else begin
            state  <= state_n;
            last   <= last_n;
            owner  <= owner_n;
            PIOsel <= sel_n;
            PIOa   <= a_n;
            PIOd   <= d_n;
            PIOwe  <= we_n;
        end
    end

`ifdef ATA_ARB_LOCK_EN
    always_ff @(posedge CLK_I or negedge nReset) begin
        if (!nReset) lock_cnt <= '0;
        else         lock_cnt <= cnt_n;
    end
`endif
endmodule

// File: tb/tb_ata_pio_arbiter.sv
// tb_ata_pio_arbiter: directed checks of grant, latch, ack routing and fairness.
module tb_ata_pio_arbiter;
    logic        CLK_I = 1'b0, nReset = 1'b0;
    logic        req0 = 0, we0 = 0, lock0 = 0, req1 = 0, we1 = 0, lock1 = 0, PIOack = 0;
    logic [3:0]  adr0 = 0, adr1 = 0;
    logic [15:0] dat0 = 0, dat1 = 0, PIOq = 0;
    logic        ack0, ack1, PIOsel, PIOwe, busy, owner;
    logic [15:0] q, PIOd;
    logic [3:0]  PIOa;
    int          n_chk = 0, n_fail = 0;

    ata_pio_arbiter #(.AW(4), .DW(16), .LOCK_MAX(4)) dut (
        .CLK_I(CLK_I), .nReset(nReset),
        .req0(req0), .adr0(adr0), .dat0(dat0), .we0(we0), .lock0(lock0), .ack0(ack0),
        .req1(req1), .adr1(adr1), .dat1(dat1), .we1(we1), .lock1(lock1), .ack1(ack1),
        .q(q), .PIOsel(PIOsel), .PIOa(PIOa), .PIOd(PIOd), .PIOwe(PIOwe),
        .PIOack(PIOack), .PIOq(PIOq), .busy(busy), .owner(owner)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #12;
        chk("rst_sel", PIOsel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_pioa", PIOa, 0);
        chk("rst_piod", PIOd, 0);
        chk("rst_piowe", PIOwe, 0);
        chk("rst_acks", {ack0, ack1}, 0);
        chk("rst_q", q, 0);
        tick();
        nReset = 1;
        // reset in the middle of an access
        req0 = 1; adr0 = 4'h3;
        tick();
        chk("pre_rst_sel", PIOsel, 1);
        req0 = 0; nReset = 0; #1;
        chk("mid_rst_sel", PIOsel, 0);
        chk("mid_rst_busy", busy, 0);
        tick();
        nReset = 1; req0 = 1; req1 = 1; adr1 = 4'h5;
        tick();
        chk("first_tie_owner", owner, 0);
        chk("first_tie_pioa", PIOa, 4'h3);
        PIOack = 1; PIOq = 16'h1234; req0 = 0; req1 = 0; #1;
        chk("first_tie_ack0", ack0, 1);
        chk("first_tie_ack1", ack1, 0);
        chk("first_tie_q", q, 16'h1234);
        tick();
        PIOack = 0; #1;
        chk("first_done_sel", PIOsel, 0);
        chk("first_done_q", q, 0);
        // single write with a long PIO access
        req0 = 1; adr0 = 4'h7; dat0 = 16'h00EC; we0 = 1;
        tick();
        chk("wr_sel", PIOsel, 1);
        req0 = 0; adr0 = 4'h0; dat0 = 16'hFFFF; we0 = 0;
        repeat (30) tick();
        chk("wr_sel_held", PIOsel, 1);
        chk("wr_pioa", PIOa, 4'h7);
        chk("wr_piod", PIOd, 16'h00EC);
        chk("wr_piowe", PIOwe, 1);
        PIOack = 1; #1;
        chk("wr_ack0", ack0, 1);
        chk("wr_ack1", ack1, 0);
        tick();
        PIOack = 0; #1;
        chk("wr_ack0_pulse", ack0, 0);
        chk("wr_sel_drop", PIOsel, 0);
        // read return to requester 1
        req1 = 1; adr1 = 4'h0; we1 = 0;
        tick();
        chk("rd_owner", owner, 1);
        chk("rd_piowe", PIOwe, 0);
        req1 = 0;
        tick();
        PIOack = 1; PIOq = 16'hA55A; #1;
        chk("rd_ack1", ack1, 1);
        chk("rd_ack0", ack0, 0);
        chk("rd_q", q, 16'hA55A);
        tick();
        PIOack = 0; #1;
        chk("rd_q_clear", q, 0);
        chk("rd_ack1_pulse", ack1, 0);
        // contention: strict alternation with an idle gap
        req0 = 1; req1 = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rr_owner%0d", i), owner, i % 2);
            chk($sformatf("rr_sel%0d", i), PIOsel, 1);
            PIOack = 1; #1;
            chk($sformatf("rr_acks%0d", i), {ack1, ack0}, (i % 2) ? 2'b10 : 2'b01);
            tick();
            PIOack = 0; #1;
            chk($sformatf("rr_gap%0d", i), {busy, PIOsel}, 0);
        end
        req0 = 0; req1 = 0;
        // abandon: requester drops req after the grant
        req0 = 1; adr0 = 4'h2;
        tick();
        chk("ab_owner", owner, 0);
        repeat (2) tick();
        req0 = 0;
        repeat (2) tick();
        chk("ab_sel_held", PIOsel, 1);
        chk("ab_busy", busy, 1);
        PIOack = 1; PIOq = 16'hBEEF; #1;
        chk("ab_ack0", ack0, 1);
        tick();
        // stray ack while idle
        chk("stray_acks", {ack0, ack1}, 0);
        chk("stray_q", q, 0);
        tick();
        chk("stray_idle", {busy, PIOsel}, 0);
        PIOack = 0;
`ifdef ATA_ARB_LOCK_EN
        // last served was 0, so requester 1 wins and holds the lock for 4 accesses
        req0 = 1; req1 = 1; lock1 = 1;
        tick();
        chk("lk_owner", owner, 1);
        for (int k = 0; k < 4; k++) begin
            PIOack = 1; #1;
            chk($sformatf("lk_ack1_%0d", k), ack1, 1);
            tick();
            PIOack = 0; #1;
            chk($sformatf("lk_gap_%0d", k), PIOsel, 0);
            if (k < 3) begin
                chk($sformatf("lk_busy_%0d", k), busy, 1);
                tick();
                chk($sformatf("lk_resel_%0d", k), {owner, PIOsel}, 2'b11);
            end
        end
        chk("lk_release", busy, 0);
        tick();
        chk("lk_next_owner", owner, 0);
        req0 = 0; req1 = 0; lock1 = 0;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
